tl_sched: RTL



---
 rtl/tl_sched_pkg.sv | 46 ++++
 rtl/tl_phase_timer.sv | 22 ++
 rtl/tl_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/tl_sched_pkg.sv
// tl_sched_pkg: shared definitions for the two-approach intersection scheduler.
//   state_t     - phase encoding, also driven out on tl_sched.phase
//   lamps_t     - one bit per lamp (A r/y/g, B r/y/g, walk)
//   lamp_decode - Moore decode from phase to lamp set
package tl_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_GRN   = 3'd1,
    A_YEL   = 3'd2,
    A_CLR   = 3'd3,
    WALK_PH = 3'd4,
    B_GRN   = 3'd5,
    B_YEL   = 3'd6,
    B_CLR   = 3'd7
  } state_t;

  typedef struct packed {
    logic a_r;
    logic a_y;
    logic a_g;
    logic b_r;
    logic b_y;
    logic b_g;
    logic walk;
  } lamps_t;

  // Red on both approaches is the safe default; only the active approach
  // swaps red for its green/yellow, so a_g and b_g can never coincide.
  function automatic lamps_t lamp_decode(state_t s);
    lamps_t l;
    l     = '0;
    l.a_r = 1'b1;
    l.b_r = 1'b1;
    case (s)
      A_GRN:   begin l.a_r = 1'b0; l.a_g = 1'b1; end
      A_YEL:   begin l.a_r = 1'b0; l.a_y = 1'b1; end
      B_GRN:   begin l.b_r = 1'b0; l.b_g = 1'b1; end
      B_YEL:   begin l.b_r = 1'b0; l.b_y = 1'b1; end
      WALK_PH: l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: cycles-in-phase counter.
//   clk, reset - clock, synchronous active-high reset
//   clear      - restart the count at 0 (phase change)
//   enable     - count this cycle
//   count      - CW-bit count, saturates at all-ones
module tl_phase_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)                      count <= '0;
    else if (clear)                 count <= '0;
    else if (enable && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/tl_sched.sv
// tl_sched: coordinated main-road (A) / side-road (B) signal scheduler with
// a pedestrian walk phase.
//   clk, reset   - clock, synchronous active-high reset
//   start        - run enable; dropping it drains the sequence to IDLE
//   car_a        - A vehicle sensor (registered, reserved, no effect)
//   car_b        - B vehicle sensor, level
//   ped_req      - pedestrian button, latched into a pending flag
//   a_r/a_y/a_g  - A lamps        b_r/b_y/b_g - B lamps
//   walk         - pedestrian lamp
//   phase        - current state encoding
// All outputs are registered and aligned with the state register.
import tl_sched_pkg::*;

module tl_sched #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW    = 3,
  parameter int ALLRED    = 2,
  parameter int WALK      = 6,
  parameter int CW        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       car_a,
  input  logic       car_b,
  input  logic       ped_req,
  output logic       a_r,
  output logic       a_y,
  output logic       a_g,
  output logic       b_r,
  output logic       b_y,
  output logic       b_g,
  output logic       walk,
  output logic [2:0] phase
);

  // Exit thresholds are "last cycle of the phase" values of the timer.
  localparam logic [CW-1:0] GMIN_L = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_L = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_L  = CW'(YELLOW - 1);
  localparam logic [CW-1:0] CLR_L  = CW'(ALLRED - 1);
  localparam logic [CW-1:0] WALK_L = CW'(WALK - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   timer;
  logic            ped_pend;
  lamps_t          lamps_q;
  logic            car_a_unused;  // held for a future A-actuated mode

  tl_phase_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_d != state_q),
    .enable (1'b1),
    .count  (timer)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = A_GRN;
      // A is the default road: it has no maximum and only yields on demand.
      A_GRN:   if (!start) state_d = A_YEL;
               else if (timer >= GMIN_L && (car_b || ped_pend)) state_d = A_YEL;
      A_YEL:   if (timer == YEL_L) state_d = A_CLR;
      A_CLR:   if (timer == CLR_L)
                 state_d = !start ? IDLE : (ped_pend ? WALK_PH : B_GRN);
      WALK_PH: if (timer == WALK_L)
                 state_d = !start ? IDLE : (car_b ? B_GRN : A_GRN);
      B_GRN:   if (!start || timer == GMAX_L || (timer >= GMIN_L && !car_b))
                 state_d = B_YEL;
      B_YEL:   if (timer == YEL_L) state_d = B_CLR;
      B_CLR:   if (timer == CLR_L)
                 state_d = !start ? IDLE : (ped_pend ? WALK_PH : A_GRN);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ped_pend     <= 1'b0;
      lamps_q      <= lamp_decode(IDLE);
      car_a_unused <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Decoding the next state keeps the lamp flops in step with state_q.
      lamps_q      <= lamp_decode(state_d);
      car_a_unused <= car_a;
      // Entering the walk phase serves the request, even one arriving now.
      if (state_d == WALK_PH && state_q != WALK_PH) ped_pend <= 1'b0;
      else if (ped_req)                             ped_pend <= 1'b1;
    end
  end

  assign a_r   = lamps_q.a_r;
  assign a_y   = lamps_q.a_y;
  assign a_g   = lamps_q.a_g;
  assign b_r   = lamps_q.b_r;
  assign b_y   = lamps_q.b_y;
  assign b_g   = lamps_q.b_g;
  assign walk  = lamps_q.walk;
  assign phase = state_q;

endmodule
